prbs_checker: RTL and testbench
===============================

// Module: prbs_checker
// PURPOSE
//  Serial PRBS checker. Sits directly downstream of the flip-flop/LFSR
//  generator chain and consumes its serial Q stream, one bit per BIT_VALID.
//  Self-synchronises to the Fibonacci LFSR sequence, then flags and counts
//  bit errors for BER measurement.
// PARAMETERS
//  WIDTH       8      LFSR length in bits
//  TAPS        8'hB8  tap mask, x^8+x^6+x^5+x^4+1; same value as the generator
//  SYNC_COUNT  16     consecutive correct predictions required to lock (>=1)
//  LOSS_THRESH 4      consecutive mismatches in LOCKED that drop lock (>=1)
//  CNT_W       16     width of ERR_CNT and BIT_CNT
// PORTS
//  CLK       in   1      clock, rising edge
//  RST       in   1      asynchronous, active-high reset
//  BIT_IN    in   1      received serial bit
//  BIT_VALID in   1      BIT_IN is sampled on this edge; low means hold
//  CLR_CNT   in   1      synchronous clear of ERR_CNT and BIT_CNT
//  LOCKED    out  1      level: checker is synchronised
//  ERR       out  1      one-cycle pulse: last valid bit mismatched while LOCKED
//  LOCK_LOST out  1      one-cycle pulse: LOCKED -> HUNT transition
//  ERR_CNT   out  CNT_W  saturating count of mismatches while LOCKED
//  BIT_CNT   out  CNT_W  saturating count of valid bits checked while LOCKED
// BEHAVIOUR
//  - Reset (async): state=HUNT; s, good_cnt, bad_cnt = 0; all outputs 0.
//  - Prediction (comb): pred = ^(s & TAPS). Match when BIT_IN == pred.
//  - Cycles with BIT_VALID=0: no state or counter change; ERR and LOCK_LOST = 0.
//  - HUNT, valid bit: s <= {s[WIDTH-2:0], BIT_IN}, so the received bit seeds
//    the register.
//    Match with s != 0: good_cnt++. Mismatch, or s == 0 (zero-lockup guard):
//    good_cnt <= 0.
//    Match that brings good_cnt to SYNC_COUNT: go to LOCKED, bad_cnt <= 0.
//  - LOCKED, valid bit: s <= {s[WIDTH-2:0], pred}. The register free-runs, so
//    one line error counts as exactly one error.
//    BIT_CNT++. On mismatch: ERR=1, ERR_CNT++, bad_cnt++. On match: bad_cnt <= 0.
//    The mismatch that brings bad_cnt to LOSS_THRESH: go to HUNT,
//    good_cnt <= 0, LOCK_LOST=1. That bit is still counted in ERR_CNT.
//  - All outputs are registered. ERR, LOCK_LOST and LOCKED update on the same
//    edge that samples the bit, so they are visible in the following cycle.
//  - Counters saturate at 2^CNT_W-1 and never wrap.
//  - CLR_CNT has priority: if it coincides with an error, both counters
//    become 0, but the ERR pulse is still issued.
//  - RST asserted mid-stream aborts immediately to HUNT. The checker relocks
//    from scratch after release.
// STRUCTURE
//  - prbs_defs.vh (shared include): HUNT/LOCKED state encodings and the
//    default polynomial constants per WIDTH (8'hB8, 16'hB400). The generator
//    includes the same file.
//  - Sub-module lfsr_predict (combinational): inputs s and TAPS, output pred.
//    The generator-side stage reuses it.
//  - Top level: 1-bit state register, s register, good_cnt and bad_cnt, the
//    two saturating counters, and the pulse registers.
// TESTING
//  1. Generator seeded 8'h01, BIT_VALID=1 -> LOCKED within WIDTH+SYNC_COUNT=24
//     bits; ERR_CNT=0 and BIT_CNT=1000 after 1000 locked bits.
//  2. After lock, invert bit #100 only -> exactly one ERR pulse, ERR_CNT=1,
//     LOCKED stays 1.
//  3. Invert 4 consecutive bits -> ERR_CNT=4, LOCK_LOST pulse on the 4th,
//     LOCKED=0; clean stream afterwards -> relock within 24 bits.
//  4. All-zero stream for 200 bits -> LOCKED never asserts; ERR_CNT=0.
//  5. BIT_VALID toggled 1/0 every cycle with a clean stream -> same lock
//     point in valid bits as test 1; no ERR during gaps.
//  6. CNT_W=4, 20 errors at LOSS_THRESH=32 -> ERR_CNT holds at 15.
//     CLR_CNT together with an error -> ERR_CNT=0, ERR=1.
//     RST mid-lock -> all outputs 0 immediately.

Source files
------------

// File: rtl/prbs_checker_pkg.sv
// Shared definitions for the serial PRBS checker and the generator side:
// FSM state encoding and the default Fibonacci tap masks per LFSR length.
package prbs_checker_pkg;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    localparam logic [15:0] TAPS_W8  = 16'h00B8;  // x^8+x^6+x^5+x^4+1
    localparam logic [15:0] TAPS_W16 = 16'hB400;  // x^16+x^14+x^13+x^11+1

    // Default tap mask for a given LFSR length (low WIDTH bits are used)
    function automatic logic [15:0] default_taps(input int unsigned width);
        case (width)
            16:      return TAPS_W16;
            default: return TAPS_W8;
        endcase
    endfunction

endpackage

// File: rtl/prbs_checker_if.sv
// Bit-stream input and status/counter outputs of the PRBS checker.
interface prbs_checker_if #(
    parameter int unsigned CNT_W = 16
);
    logic             bit_in;
    logic             bit_valid;
    logic             clr_cnt;
    logic             locked;
    logic             err;
    logic             lock_lost;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] bit_cnt;

    modport master (
        output bit_in, bit_valid, clr_cnt,
        input  locked, err, lock_lost, err_cnt, bit_cnt
    );

    modport slave (
        input  bit_in, bit_valid, clr_cnt,
        output locked, err, lock_lost, err_cnt, bit_cnt
    );
endinterface

// File: rtl/prbs_checker_lfsr_predict.sv
// Next-bit prediction of a Fibonacci LFSR; shared with the generator stage.
module prbs_checker_lfsr_predict #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] taps,
    output logic             pred_c
);
    assign pred_c = ^(s & taps);
endmodule

// File: rtl/prbs_checker.sv
// Serial PRBS checker: self-synchronises to the LFSR stream, then flags and
// counts bit errors for BER measurement.
module prbs_checker
    import prbs_checker_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] TAPS        = WIDTH'(default_taps(WIDTH)),
    parameter int unsigned      SYNC_COUNT  = 16,
    parameter int unsigned      LOSS_THRESH = 4,
    parameter int unsigned      CNT_W       = 16
) (
    input  logic          CLK,
    input  logic          RST,
    prbs_checker_if.slave bus
);
    localparam int unsigned GW = $clog2(SYNC_COUNT + 1);
    localparam int unsigned BW = $clog2(LOSS_THRESH + 1);
    localparam logic [GW-1:0] GOOD_LAST = GW'(SYNC_COUNT - 1);
    localparam logic [BW-1:0] BAD_LAST  = BW'(LOSS_THRESH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [GW-1:0]    good_q, good_d;
    logic [BW-1:0]    bad_q, bad_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             err_q, err_d;
    logic             lost_q, lost_d;
    logic             pred_c;
    logic             match_c;

    prbs_checker_lfsr_predict #(.WIDTH(WIDTH)) u_predict (
        .s      (s_q),
        .taps   (TAPS),
        .pred_c (pred_c)
    );

    assign match_c = (bus.bit_in == pred_c);

    // Next-state, sync tracking and counter logic
    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        good_d    = good_q;
        bad_d     = bad_q;
        err_cnt_d = err_cnt_q;
        bit_cnt_d = bit_cnt_q;
        err_d     = 1'b0;
        lost_d    = 1'b0;

        if (bus.bit_valid) begin
            if (state_q == ST_HUNT) begin
                // Received bits seed the register; all-zero state never counts
                s_d = {s_q[WIDTH-2:0], bus.bit_in};
                if (match_c && (s_q != '0)) begin
                    good_d = good_q + GW'(1);
                    if (good_q == GOOD_LAST) begin
                        state_d = ST_LOCKED;
                        bad_d   = '0;
                    end
                end else begin
                    good_d = '0;
                end
            end else begin
                // Free-running so a single line error costs exactly one error
                s_d = {s_q[WIDTH-2:0], pred_c};
                if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (!match_c) begin
                    err_d = 1'b1;
                    if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
                    if (bad_q == BAD_LAST) begin
                        state_d = ST_HUNT;
                        good_d  = '0;
                        bad_d   = '0;
                        lost_d  = 1'b1;
                    end else begin
                        bad_d = bad_q + BW'(1);
                    end
                end else begin
                    bad_d = '0;
                end
            end
        end

        if (bus.clr_cnt) begin
            err_cnt_d = '0;
            bit_cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_HUNT;
            s_q       <= '0;
            good_q    <= '0;
            bad_q     <= '0;
            err_cnt_q <= '0;
            bit_cnt_q <= '0;
            err_q     <= 1'b0;
            lost_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            good_q    <= good_d;
            bad_q     <= bad_d;
            err_cnt_q <= err_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            err_q     <= err_d;
            lost_q    <= lost_d;
        end
    end

    assign bus.locked    = (state_q == ST_LOCKED);
    assign bus.err       = err_q;
    assign bus.lock_lost = lost_q;
    assign bus.err_cnt   = err_cnt_q;
    assign bus.bit_cnt   = bit_cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: two instances (default, and CNT_W=4/LOSS_THRESH=32)
// share one stimulus stream and are compared every cycle to a bit-history model.
module tb_prbs_checker;
    localparam logic [7:0] TAPS = 8'hB8;
    localparam int         SYNC = 16;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    logic bit_in = 1'b0, bit_valid = 1'b0, clr_cnt = 1'b0;
    int   vectors = 0, miscompares = 0;
    logic [7:0] g;

    prbs_checker_if #(.CNT_W(16)) ifa ();
    prbs_checker_if #(.CNT_W(4))  ifb ();

    assign ifa.bit_in = bit_in;  assign ifa.bit_valid = bit_valid;  assign ifa.clr_cnt = clr_cnt;
    assign ifb.bit_in = bit_in;  assign ifb.bit_valid = bit_valid;  assign ifb.clr_cnt = clr_cnt;

    prbs_checker u_a (.CLK(CLK), .RST(RST), .bus(ifa));
    prbs_checker #(.CNT_W(4), .LOSS_THRESH(32)) u_b (.CLK(CLK), .RST(RST), .bus(ifb));

    // Reference: hist[0] is the newest bit of the reference sequence
    typedef struct packed {
        bit       locked;
        bit [7:0] hist;
        int       good;
        int       bad;
        int       errc;
        int       bitc;
        bit       err;
        bit       lost;
    } model_t;

    model_t ma = '0, mb = '0;

    function automatic model_t step(input model_t m, input bit b, input bit v,
                                    input bit clr, input int loss, input int cmax);
        bit p, nz, ok, nb;
        m.err  = 1'b0;
        m.lost = 1'b0;
        if (v) begin
            p = 1'b0; nz = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (TAPS[i]) p = p ^ m.hist[i];
                if (m.hist[i]) nz = 1'b1;
            end
            ok = (b == p);
            nb = m.locked ? p : b;
            for (int i = 7; i > 0; i--) m.hist[i] = m.hist[i-1];
            m.hist[0] = nb;
            if (!m.locked) begin
                if (ok && nz) begin
                    m.good = m.good + 1;
                    if (m.good == SYNC) begin m.locked = 1'b1; m.bad = 0; end
                end else m.good = 0;
            end else begin
                m.bitc = (m.bitc < cmax) ? m.bitc + 1 : cmax;
                if (!ok) begin
                    m.err  = 1'b1;
                    m.errc = (m.errc < cmax) ? m.errc + 1 : cmax;
                    m.bad  = m.bad + 1;
                    if (m.bad == loss) begin
                        m.locked = 1'b0; m.good = 0; m.bad = 0; m.lost = 1'b1;
                    end
                end else m.bad = 0;
            end
        end
        if (clr) begin m.errc = 0; m.bitc = 0; end
        return m;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            ma = '0;
            mb = '0;
        end else begin
            ma = step(ma, bit_in, bit_valid, clr_cnt, 4, 65535);
            mb = step(mb, bit_in, bit_valid, clr_cnt, 32, 15);
        end
    end

    always @(negedge CLK) begin
        check("cycle_a", 64'({ifa.locked, ifa.err, ifa.lock_lost, ifa.err_cnt, ifa.bit_cnt}),
              64'({ma.locked, ma.err, ma.lost, 16'(ma.errc), 16'(ma.bitc)}));
        check("cycle_b", 64'({ifb.locked, ifb.err, ifb.lock_lost, ifb.err_cnt, ifb.bit_cnt}),
              64'({mb.locked, mb.err, mb.lost, 4'(mb.errc), 4'(mb.bitc)}));
    end

    task automatic gen(output bit b);
        b = ^(g & TAPS);
        g = {g[6:0], b};
    endtask

    task automatic send(input bit b, input bit v, input bit c);
        bit_in = b; bit_valid = v; clr_cnt = c;
        @(posedge CLK); #1;
    endtask

    task automatic reset_dut();
        bit_valid = 1'b0; clr_cnt = 1'b0;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    initial begin
        bit b, ever, flip, clr, v;
        int n, n1, errs, burst;

        repeat (3) @(posedge CLK);
        #1;
        check("reset_a", 64'({ifa.locked, ifa.err, ifa.lock_lost, ifa.err_cnt, ifa.bit_cnt}), 64'd0);
        RST = 1'b0;

        // Clean stream from seed 01: lock point and 1000 locked bits
        g = 8'h01; n = 0;
        for (int i = 0; i < 30; i++) begin
            gen(b); send(b, 1'b1, 1'b0); n++;
            if (ifa.locked) break;
        end
        check("lock_within_24", 64'(n <= 24 && ifa.locked), 64'd1);
        check("model_locked", 64'(ma.locked), 64'd1);
        n1 = n;
        repeat (1000) begin gen(b); send(b, 1'b1, 1'b0); end
        check("bit_cnt_1000", 64'(ifa.bit_cnt), 64'd1000);
        check("err_cnt_clean", 64'(ifa.err_cnt), 64'd0);
        check("model_bitc_1000", 64'(ma.bitc), 64'd1000);
        check("b_bit_cnt_sat", 64'(ifb.bit_cnt), 64'd15);

        // Single inverted bit
        gen(b); send(b, 1'b1, 1'b1);
        errs = 0;
        for (int i = 1; i <= 150; i++) begin
            gen(b); send(b ^ (i == 100), 1'b1, 1'b0);
            errs += int'(ifa.err);
        end
        check("single_err_pulses", 64'(errs), 64'd1);
        check("single_err_cnt", 64'(ifa.err_cnt), 64'd1);
        check("single_err_locked", 64'(ifa.locked), 64'd1);

        // Four consecutive errors drop lock, then relock
        gen(b); send(b, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin gen(b); send(~b, 1'b1, 1'b0); end
        check("loss_pulse", 64'(ifa.lock_lost), 64'd1);
        check("loss_unlocked", 64'(ifa.locked), 64'd0);
        check("loss_err_cnt", 64'(ifa.err_cnt), 64'd4);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            gen(b); send(b, 1'b1, 1'b0); n++;
            if (ifa.locked) break;
        end
        check("relock_within_24", 64'(n <= 24 && ifa.locked), 64'd1);

        // Valid toggling: same lock point in valid bits
        reset_dut();
        g = 8'h01; n = 0;
        for (int i = 0; i < 80 && !ifa.locked; i++) begin
            if (i % 2 == 0) begin gen(b); send(b, 1'b1, 1'b0); n++; end
            else send(1'($urandom), 1'b0, 1'b0);
        end
        check("gap_lock_point", 64'(n), 64'(n1));

        // All-zero stream never locks
        reset_dut();
        ever = 1'b0;
        repeat (200) begin send(1'b0, 1'b1, 1'b0); ever |= ifa.locked; end
        check("zero_never_locks", 64'(ever), 64'd0);
        check("zero_err_cnt", 64'(ifa.err_cnt), 64'd0);

        // Narrow counter saturation, clear with error, async reset
        reset_dut();
        g = 8'h5A;
        for (int i = 0; i < 30 && !ifb.locked; i++) begin gen(b); send(b, 1'b1, 1'b0); end
        repeat (20) begin gen(b); send(~b, 1'b1, 1'b0); end
        check("b_err_sat", 64'(ifb.err_cnt), 64'd15);
        check("b_still_locked", 64'(ifb.locked), 64'd1);
        gen(b); send(~b, 1'b1, 1'b1);
        check("clr_err_pulse", 64'(ifb.err), 64'd1);
        check("clr_err_cnt", 64'(ifb.err_cnt), 64'd0);
        gen(b); send(~b, 1'b1, 1'b0);
        RST = 1'b1;
        #1;
        check("async_rst_b", 64'({ifb.locked, ifb.err, ifb.lock_lost, ifb.err_cnt, ifb.bit_cnt}), 64'd0);
        check("async_rst_a", 64'({ifa.locked, ifa.err, ifa.lock_lost, ifa.err_cnt, ifa.bit_cnt}), 64'd0);
        @(posedge CLK); #1;
        RST = 1'b0;

        // Randomised stream: gaps, sparse errors, bursts, clears
        g = 8'($urandom_range(1, 255));
        burst = 0;
        repeat (4000) begin
            v    = ($urandom % 5) != 0;
            clr  = ($urandom % 150) == 0;
            if (v) begin
                flip = ($urandom % 40) == 0;
                if ($urandom % 400 == 0) burst = 6;
                if (burst > 0) begin flip = 1'b1; burst--; end
                gen(b); send(b ^ flip, 1'b1, clr);
            end else send(1'($urandom), 1'b0, clr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
